// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface multicycle_controller_if #(
    parameter int RETIRE_CNT_W = 32
);
    logic [5:0]              op;
    logic [5:0]              funct;
    logic                    zero;
    logic                    mem_ready;
    logic                    mem_req;
    logic                    mem_we;
    logic                    iord;
    logic                    irwrite;
    logic                    pcen;
    logic [1:0]              pcsrc;
    logic                    alusrca;
    logic [1:0]              alusrcb;
    logic [2:0]              alucontrol;
    logic                    regwrite;
    logic                    regdst;
    logic                    memtoreg;
    logic                    illegal;
    logic [RETIRE_CNT_W-1:0] retired;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_we, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regwrite, regdst, memtoreg, illegal, retired
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regwrite, regdst, memtoreg, illegal, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Per-cycle control schedule for the shared multicycle MIPS datapath.
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | branch target into ALUOut, dispatch on op/funct
// MEMADR   | effective address A + imm
// MEMRD    | load data read, wait for mem_ready
// MEMWB    | write load data to rt
// MEMWR    | store data write, wait for mem_ready
// RTYPE_EX | ALU op on A,B selected by funct
// RTYPE_WB | write ALU result to rd
// BEQ      | compare A,B; take branch when zero
// ADDI_EX  | A + imm
// ADDI_WB  | write result to rt
// JUMP     | PC <= jump target
// ILLEGAL  | halted, exit only by reset
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int RETIRE_CNT_W    = 32
) (
    input  logic clk,
    input  logic reset_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE_EX,
        S_RTYPE_WB, S_BEQ, S_ADDI_EX, S_ADDI_WB, S_JUMP, S_ILLEGAL
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_illegal;
    logic [RETIRE_CNT_W-1:0] r_retired;
    logic                    w_funct_ok;
    logic [2:0]              w_rtype_alu;
    logic                    w_retire;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_rtype_alu = 3'b010;
        case (bus.funct)
            6'b100001: w_rtype_alu = 3'b010;
            6'b100011: w_rtype_alu = 3'b110;
            6'b100100: w_rtype_alu = 3'b000;
            6'b100101: w_rtype_alu = 3'b001;
            6'b101011: w_rtype_alu = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    6'b000000: w_next = w_funct_ok ? S_RTYPE_EX : S_ILLEGAL;
                    6'b100011,
                    6'b101011: w_next = S_MEMADR;
                    6'b000100: w_next = S_BEQ;
                    6'b001001: w_next = S_ADDI_EX;
                    6'b000010: w_next = S_JUMP;
                    default:   w_next = S_ILLEGAL;
                endcase
                // Non-halting build drops the bad instruction and refetches.
                if (w_next == S_ILLEGAL && !HALT_ON_ILLEGAL) w_next = S_FETCH;
            end
            S_MEMADR:   w_next = (bus.op == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWR:    if (bus.mem_ready) w_next = S_FETCH;
            S_RTYPE_EX: w_next = S_RTYPE_WB;
            S_ADDI_EX:  w_next = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_BEQ, S_ADDI_WB, S_JUMP: w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWR && bus.mem_ready) ||
                      (r_state == S_RTYPE_WB) || (r_state == S_BEQ) ||
                      (r_state == S_ADDI_WB) || (r_state == S_JUMP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
            if (w_retire) r_retired <= r_retired + RETIRE_CNT_W'(1);
        end
    end

    // Outputs decode from state only, except the handshake/zero qualified enables.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcen       = 1'b0;
        bus.pcsrc      = 2'b00;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.alucontrol = 3'b010;
        bus.regwrite   = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.alusrcb = 2'b01;
                    bus.irwrite = bus.mem_ready;
                    bus.pcen    = bus.mem_ready;
                end
                S_DECODE:   bus.alusrcb = 2'b11;
                S_MEMADR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_MEMWB: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_RTYPE_EX: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = w_rtype_alu;
                end
                S_RTYPE_WB: begin
                    bus.regwrite   = 1'b1;
                    bus.regdst     = 1'b1;
                    bus.alucontrol = w_rtype_alu;
                end
                S_BEQ: begin
                    bus.alusrca    = 1'b1;
                    bus.alucontrol = 3'b110;
                    bus.pcsrc      = 2'b01;
                    bus.pcen       = bus.zero;
                end
                S_ADDI_EX: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                end
                S_ADDI_WB:  bus.regwrite = 1'b1;
                S_JUMP: begin
                    bus.pcsrc = 2'b10;
                    bus.pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.illegal = r_illegal;
    assign bus.retired = r_retired;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: halting and non-halting builds driven in lockstep.
module tb_multicycle_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [5:0] op_d, funct_d;
    logic       zero_d, ready_d;

    multicycle_controller_if #(.RETIRE_CNT_W(32)) bus_h ();
    multicycle_controller_if #(.RETIRE_CNT_W(32)) bus_n ();

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1), .RETIRE_CNT_W(32)) u_dut_halt (
        .clk(clk), .reset_n(reset_n), .bus(bus_h)
    );
    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0), .RETIRE_CNT_W(32)) u_dut_nop (
        .clk(clk), .reset_n(reset_n), .bus(bus_n)
    );

    assign bus_h.op = op_d;    assign bus_n.op = op_d;
    assign bus_h.funct = funct_d; assign bus_n.funct = funct_d;
    assign bus_h.zero = zero_d;  assign bus_n.zero = zero_d;
    assign bus_h.mem_ready = ready_d; assign bus_n.mem_ready = ready_d;

    wire [15:0] obs_h = {bus_h.mem_req, bus_h.mem_we, bus_h.iord, bus_h.irwrite, bus_h.pcen,
                         bus_h.pcsrc, bus_h.alusrca, bus_h.alusrcb, bus_h.alucontrol,
                         bus_h.regwrite, bus_h.regdst, bus_h.memtoreg};
    wire [15:0] obs_n = {bus_n.mem_req, bus_n.mem_we, bus_n.iord, bus_n.irwrite, bus_n.pcen,
                         bus_n.pcsrc, bus_n.alusrca, bus_n.alusrcb, bus_n.alucontrol,
                         bus_n.regwrite, bus_n.regdst, bus_n.memtoreg};

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] q_h[$];
    logic [15:0] q_n[$];
    string       q_tag[$];

    function automatic logic [15:0] cv(input logic req, we, iord, irw, pcen, input logic [1:0] pcsrc,
                                       input logic srca, input logic [1:0] srcb, input logic [2:0] alu,
                                       input logic rw, rdst, m2r);
        return {req, we, iord, irw, pcen, pcsrc, srca, srcb, alu, rw, rdst, m2r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock step: drive at negedge, queue expectations, compare 1 ns later.
    task automatic cyc(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input logic [15:0] eh, input logic [15:0] en);
        string t;
        @(negedge clk);
        op_d = o; funct_d = f; zero_d = z; ready_d = r;
        q_h.push_back(eh); q_n.push_back(en); q_tag.push_back(tag);
        #1;
        t = q_tag.pop_front();
        chk({t, "/halt"}, {16'h0, obs_h}, {16'h0, q_h.pop_front()});
        chk({t, "/nop"},  {16'h0, obs_n}, {16'h0, q_n.pop_front()});
    endtask

    task automatic chk_st(input string tag, input logic ill_h, input int ret_h,
                          input logic ill_n, input int ret_n);
        chk({tag, "/illegal_halt"}, {31'h0, bus_h.illegal}, {31'h0, ill_h});
        chk({tag, "/retired_halt"}, bus_h.retired, ret_h);
        chk({tag, "/illegal_nop"},  {31'h0, bus_n.illegal}, {31'h0, ill_n});
        chk({tag, "/retired_nop"},  bus_n.retired, ret_n);
    endtask

    logic [15:0] C_DEF, F_WAIT, F_GO, DEC, MADR, MRD, MWB, MWR, BEQ_T, BEQ_N, AEX, AWB, JMP;
    logic [5:0]  fn_tab [5];
    logic [2:0]  alu_tab[5];

    initial begin
        C_DEF  = cv(0,0,0,0,0,2'b00,0,2'b00,3'b010,0,0,0);
        F_WAIT = cv(1,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0);
        F_GO   = cv(1,0,0,1,1,2'b00,0,2'b01,3'b010,0,0,0);
        DEC    = cv(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0);
        MADR   = cv(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0);
        MRD    = cv(1,0,1,0,0,2'b00,0,2'b00,3'b010,0,0,0);
        MWB    = cv(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,0,1);
        MWR    = cv(1,1,1,0,0,2'b00,0,2'b00,3'b010,0,0,0);
        BEQ_T  = cv(0,0,0,0,1,2'b01,1,2'b00,3'b110,0,0,0);
        BEQ_N  = cv(0,0,0,0,0,2'b01,1,2'b00,3'b110,0,0,0);
        AEX    = cv(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0);
        AWB    = cv(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,0,0);
        JMP    = cv(0,0,0,0,1,2'b10,0,2'b00,3'b010,0,0,0);
        fn_tab  = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101011};
        alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        reset_n = 1'b0; op_d = 6'd0; funct_d = 6'b100001; zero_d = 1'b0; ready_d = 1'b1;
        #12;
        chk("reset_outputs_halt", {16'h0, obs_h}, {16'h0, C_DEF});
        chk("reset_outputs_nop",  {16'h0, obs_n}, {16'h0, C_DEF});
        chk_st("reset", 1'b0, 0, 1'b0, 0);
        @(posedge clk); #2 reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc("rt_fetch",  6'd0, fn_tab[i], 0, 1, F_GO, F_GO);
            cyc("rt_decode", 6'd0, fn_tab[i], 0, 1, DEC, DEC);
            cyc("rt_ex", 6'd0, fn_tab[i], 0, 1,
                cv(0,0,0,0,0,2'b00,1,2'b00,alu_tab[i],0,0,0), cv(0,0,0,0,0,2'b00,1,2'b00,alu_tab[i],0,0,0));
            cyc("rt_wb", 6'd0, fn_tab[i], 0, 1,
                cv(0,0,0,0,0,2'b00,0,2'b00,alu_tab[i],1,1,0), cv(0,0,0,0,0,2'b00,0,2'b00,alu_tab[i],1,1,0));
        end

        cyc("lw_fetch",  6'b100011, 6'd0, 0, 1, F_GO, F_GO);
        chk_st("after_rtype", 1'b0, 5, 1'b0, 5);
        cyc("lw_decode", 6'b100011, 6'd0, 0, 1, DEC, DEC);
        cyc("lw_madr",   6'b100011, 6'd0, 0, 1, MADR, MADR);
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 6'b100011, 6'd0, 0, 0, MRD, MRD);
        cyc("lw_rd_go",  6'b100011, 6'd0, 0, 1, MRD, MRD);
        cyc("lw_wb",     6'b100011, 6'd0, 0, 1, MWB, MWB);

        cyc("beqt_fetch",  6'b000100, 6'd0, 1, 1, F_GO, F_GO);
        chk_st("after_lw", 1'b0, 6, 1'b0, 6);
        cyc("beqt_decode", 6'b000100, 6'd0, 1, 1, DEC, DEC);
        cyc("beqt_ex",     6'b000100, 6'd0, 1, 1, BEQ_T, BEQ_T);
        cyc("beqn_fwait",  6'b000100, 6'd0, 0, 0, F_WAIT, F_WAIT);
        cyc("beqn_fetch",  6'b000100, 6'd0, 0, 1, F_GO, F_GO);
        cyc("beqn_decode", 6'b000100, 6'd0, 0, 1, DEC, DEC);
        cyc("beqn_ex",     6'b000100, 6'd0, 0, 1, BEQ_N, BEQ_N);

        cyc("sw_fetch",  6'b101011, 6'd0, 0, 1, F_GO, F_GO);
        chk_st("after_beq", 1'b0, 8, 1'b0, 8);
        cyc("sw_decode", 6'b101011, 6'd0, 0, 1, DEC, DEC);
        cyc("sw_madr",   6'b101011, 6'd0, 0, 1, MADR, MADR);
        cyc("sw_wr_wait", 6'b101011, 6'd0, 0, 0, MWR, MWR);
        cyc("sw_wr_go",  6'b101011, 6'd0, 0, 1, MWR, MWR);

        cyc("j_fetch",  6'b000010, 6'd0, 0, 1, F_GO, F_GO);
        chk_st("after_sw", 1'b0, 9, 1'b0, 9);
        cyc("j_decode", 6'b000010, 6'd0, 0, 1, DEC, DEC);
        cyc("j_ex",     6'b000010, 6'd0, 0, 1, JMP, JMP);

        cyc("addi_fetch",  6'b001001, 6'd0, 0, 1, F_GO, F_GO);
        chk_st("after_j", 1'b0, 10, 1'b0, 10);
        cyc("addi_decode", 6'b001001, 6'd0, 0, 1, DEC, DEC);
        cyc("addi_ex",     6'b001001, 6'd0, 0, 1, AEX, AEX);
        cyc("addi_wb",     6'b001001, 6'd0, 0, 1, AWB, AWB);

        // Reset in the middle of a store wait: instruction abandoned, counter cleared.
        cyc("swr_fetch",  6'b101011, 6'd0, 0, 1, F_GO, F_GO);
        chk_st("after_addi", 1'b0, 11, 1'b0, 11);
        cyc("swr_decode", 6'b101011, 6'd0, 0, 1, DEC, DEC);
        cyc("swr_madr",   6'b101011, 6'd0, 0, 1, MADR, MADR);
        cyc("swr_wait",   6'b101011, 6'd0, 0, 0, MWR, MWR);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_outputs_halt", {16'h0, obs_h}, {16'h0, C_DEF});
        chk("midreset_outputs_nop",  {16'h0, obs_n}, {16'h0, C_DEF});
        chk_st("midreset", 1'b0, 0, 1'b0, 0);
        @(posedge clk); #2 reset_n = 1'b1;
        cyc("post_reset_fetch", 6'd0, 6'b100001, 0, 1, F_GO, F_GO);
        chk_st("post_reset", 1'b0, 0, 1'b0, 0);
        cyc("post_reset_decode", 6'd0, 6'b100001, 0, 1, DEC, DEC);
        cyc("post_reset_ex", 6'd0, 6'b100001, 0, 1,
            cv(0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0), cv(0,0,0,0,0,2'b00,1,2'b00,3'b010,0,0,0));
        cyc("post_reset_wb", 6'd0, 6'b100001, 0, 1,
            cv(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,1,0), cv(0,0,0,0,0,2'b00,0,2'b00,3'b010,1,1,0));

        cyc("ill_fetch",  6'b111111, 6'd0, 0, 1, F_GO, F_GO);
        cyc("ill_decode", 6'b111111, 6'd0, 0, 1, DEC, DEC);
        for (int i = 0; i < 10; i++) begin
            cyc("ill_hold", 6'b111111, 6'd0, 0, 1, C_DEF, (i % 2 == 0) ? F_GO : DEC);
            chk_st("ill_hold", 1'b1, 1, 1'b0, 1);
        end

        reset_n = 1'b0;
        #1 chk_st("ill_reset", 1'b0, 0, 1'b0, 0);
        @(posedge clk); #2 reset_n = 1'b1;
        cyc("badfn_fetch",  6'd0, 6'b000000, 0, 1, F_GO, F_GO);
        cyc("badfn_decode", 6'd0, 6'b000000, 0, 1, DEC, DEC);
        cyc("badfn_next",   6'd0, 6'b000000, 0, 1, C_DEF, F_GO);
        chk_st("badfn", 1'b1, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: one ALU, one unified instruction/data memory, register file, IR, PC.
- Supported instructions: addu, subu, and, or, sltu, lw, sw, beq, addiu, j.
- Replaces per-instruction combinational decoding with a per-cycle control schedule.
- Handles a ready-based memory handshake and traps illegal encodings.

Parameters:
HALT_ON_ILLEGAL, 1, 1: illegal op/funct enters sticky ILLEGAL state; 0: treated as NOP, return to FETCH
RETIRE_CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], from IR register (stable after FETCH)
funct  in  6  IR[5:0]
zero  in  1  ALU result == 0
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  write request (valid with mem_req)
iord  out  1  address mux: 0 = PC, 1 = ALUOut
irwrite  out  1  load IR from memory read data
pcen  out  1  PC write enable
pcsrc  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 sltu
regwrite  out  1  register file write enable
regdst  out  1  0 = rt (IR[20:16]), 1 = rd (IR[15:11])
memtoreg  out  1  1 = write back memory data
illegal  out  1  sticky illegal-instruction flag
retired  out  RETIRE_CNT_W  count of completed instructions, wraps modulo 2^W

Behaviour:
- Reset (async, reset_n low): state = FETCH, illegal = 0, retired = 0. All outputs forced to defaults while reset_n low.
- Defaults (any state not overriding): all 1-bit outputs 0, pcsrc = 00, alusrcb = 00, alucontrol = 010.
- FETCH: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, add.
  - Hold while mem_ready = 0; irwrite/pcen stay 0.
  - On mem_ready = 1: irwrite = 1, pcen = 1 (PC <= PC+4) -> DECODE.
- DECODE: alusrca = 0, alusrcb = 11, add (branch target into ALUOut). Dispatch on op:
  - 000000 -> RTYPE_EX, but only if funct is in {100001, 100011, 100100, 100101, 101011}; otherwise illegal.
  - 100011 / 101011 -> MEMADR
  - 000100 -> BEQ
  - 001001 -> ADDI_EX
  - 000010 -> JUMP
  - Any other op -> illegal.
- Illegal handling: HALT_ON_ILLEGAL = 1 -> ILLEGAL, with illegal set to 1 on entry. HALT_ON_ILLEGAL = 0 -> FETCH, no retire.
- MEMADR: alusrca = 1, alusrcb = 10, add. -> MEMRD if op = 100011, else MEMWR.
- MEMRD: mem_req = 1, iord = 1. Wait for mem_ready, then -> MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1 -> FETCH.
- MEMWR: mem_req = 1, mem_we = 1, iord = 1. Wait for mem_ready, then -> FETCH.
- RTYPE_EX: alusrca = 1, alusrcb = 00, alucontrol from funct:
  - 100001 -> 010
  - 100011 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101011 -> 111
  - Next state: RTYPE_WB.
- RTYPE_WB: regwrite = 1, regdst = 1, alucontrol held as in RTYPE_EX -> FETCH.
- BEQ: alusrca = 1, alusrcb = 00, sub, pcsrc = 01, pcen = zero -> FETCH.
- ADDI_EX: alusrca = 1, alusrcb = 10, add -> ADDI_WB.
- ADDI_WB: regwrite = 1, regdst = 0 -> FETCH.
- JUMP: pcsrc = 10, pcen = 1 -> FETCH.
- ILLEGAL: all outputs default, no memory requests. Exit only via reset.
- Retire: retired increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready), RTYPE_WB, BEQ (taken or not), ADDI_WB, JUMP.
- Minimum latency (mem_ready tied 1): lw 5 cycles; sw, R-type, addiu 4 cycles; beq, j 3 cycles.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Asynchronous reset mid-instruction (including during a memory wait): abandon the instruction, no retire, return to FETCH.

Test Plan:
- Reset, mem_ready = 1, op = 000000 funct = 100001 -> states FETCH, DECODE, RTYPE_EX, RTYPE_WB; alucontrol = 010 in EX; regwrite = 1, regdst = 1 in cycle 4; retired = 1.
- lw (op 100011) with mem_ready low 3 cycles in MEMRD -> mem_req = 1, iord = 1 held 4 cycles; memtoreg = 1, regwrite = 1 in MEMWB; total 8 cycles.
- beq with zero = 1 then zero = 0 -> pcen = 1, pcsrc = 01 only in first; both take 3 cycles; retired = 2.
- sw (op 101011) -> mem_we = 1 with mem_req in MEMWR, regwrite never 1; j (op 000010) -> pcsrc = 10, pcen = 1 in cycle 3.
- op = 111111 with HALT_ON_ILLEGAL = 1 -> illegal = 1, mem_req stays 0 for 10 cycles. With HALT_ON_ILLEGAL = 0 -> FETCH next, retired unchanged.
- reset_n low during MEMWR wait -> outputs default immediately; after release, FETCH with mem_req = 1, retired = 0.
